// File: rtl/fifo_lcd_bridge.sv
// fifo_lcd_bridge
//   Pops 9-bit words from a sync FIFO read port and offers each one as a single
//   valid/ready transaction to the HD44780 LCD controller host port.
//   Word format: [8] = RS (0 command, 1 data), [7:0] = byte.
//   No pops are issued until the LCD controller reports init_done.
//
// Parameters
//   FIFO_RD_LATENCY : 0 = first-word-fall-through, 1 = registered read
//   WORD_W          : FIFO word width, fixed at 9
//
// Ports
//   clk, rst                         : clock, synchronous active-high reset
//   fifo_empty, fifo_dout, fifo_rd_en: FIFO read side
//   init_done                        : LCD controller init complete
//   host_valid/host_ready/host_rs/host_data : LCD controller host side
//
// Optional build macro FIFO_LCD_BRIDGE_STATS_EN adds:
//   txn_count[15:0] : wrapping count of host transfers
//   stall_flag      : sticky, set after 1024 consecutive stalled cycles
module fifo_lcd_bridge #(
  parameter int FIFO_RD_LATENCY = 1,
  parameter int WORD_W          = 9
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              fifo_empty,
  input  logic [WORD_W-1:0] fifo_dout,
  output logic              fifo_rd_en,
  input  logic              init_done,
  input  logic              host_ready,
  output logic              host_valid,
  output logic              host_rs,
`ifdef FIFO_LCD_BRIDGE_STATS_EN
  output logic [15:0]       txn_count,
  output logic              stall_flag,
`endif
  output logic [7:0]        host_data
);

  generate
    if (FIFO_RD_LATENCY != 0 && FIFO_RD_LATENCY != 1) begin : g_bad_lat
      $error("fifo_lcd_bridge: FIFO_RD_LATENCY must be 0 or 1");
    end
    if (WORD_W != 9) begin : g_bad_w
      $error("fifo_lcd_bridge: WORD_W must be 9");
    end
  endgenerate

  localparam bit FWFT = (FIFO_RD_LATENCY == 0);

  typedef enum logic [1:0] {IDLE, POP, WAIT, PRESENT} state_t;

  typedef struct packed {
    logic       rs;
    logic [7:0] data;
  } lcd_word_t;

  state_t    state, state_nxt;
  lcd_word_t hold_q;

  logic can_pop;
  logic capture;
  logic xfer;

  // A pop is only ever launched from IDLE or right after a transfer, i.e. when
  // no word is held, so the hold register can never be overwritten early.
  assign can_pop = init_done && !fifo_empty;
  assign xfer    = (state == PRESENT) && host_ready;
  // FWFT data is valid alongside rd_en; registered data one cycle later.
  assign capture = FWFT ? (state == POP) : (state == WAIT);

  // state register
  always_ff @(posedge clk) begin
    if (rst) state <= IDLE;
    else     state <= state_nxt;
  end

  // next state
  always_comb begin
    state_nxt = state;
    unique case (state)
      IDLE:    if (can_pop) state_nxt = POP;
      POP:     state_nxt = FWFT ? PRESENT : WAIT;
      WAIT:    state_nxt = PRESENT;
      PRESENT: if (host_ready) state_nxt = can_pop ? POP : IDLE;
      default: state_nxt = IDLE;
    endcase
  end

  // outputs decoded from state / hold register
  always_comb begin
    fifo_rd_en = (state == POP);
    host_valid = (state == PRESENT);
    host_rs    = hold_q.rs;
    host_data  = hold_q.data;
  end

  // hold register keeps its value after a transfer; only reset clears it
  always_ff @(posedge clk) begin
    if (rst)          hold_q <= '0;
    else if (capture) hold_q <= lcd_word_t'(fifo_dout[8:0]);
  end

`ifdef FIFO_LCD_BRIDGE_STATS_EN
  logic [9:0] stall_cnt;

  always_ff @(posedge clk) begin
    if (rst) begin
      txn_count  <= '0;
      stall_cnt  <= '0;
      stall_flag <= 1'b0;
    end else begin
      if (xfer) txn_count <= txn_count + 16'd1;
      if (host_valid && !host_ready) begin
        // stall_cnt holds the number of prior stalled cycles in this run
        if (stall_cnt == 10'd1023) stall_flag <= 1'b1;
        else                       stall_cnt  <= stall_cnt + 10'd1;
      end else begin
        stall_cnt <= '0;
      end
    end
  end
`endif

endmodule

// File: tb/tb_fifo_lcd_bridge.sv
// Directed bench for fifo_lcd_bridge: one instance with registered FIFO read
// (u_a) and one with first-word-fall-through (u_b), each fed by a small FIFO
// model, with per-instance scoreboards checked on every host transfer.
module tb_fifo_lcd_bridge;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic rst, init_done, rdy_a, rdy_b;
  logic ef_a, rd_a, v_a, rs_a;
  logic ef_b, rd_b, v_b, rs_b;
  logic [7:0] d_a, d_b;
  logic [8:0] dout_a = '0;
  logic [8:0] dout_b;
`ifdef FIFO_LCD_BRIDGE_STATS_EN
  logic [15:0] tc_a, tc_b;
  logic        sf_a, sf_b;
`endif

  int checks = 0;
  int errors = 0;
  int n_xfer_a = 0;

  logic [8:0] sb_a[$];
  logic [8:0] sb_b[$];

  // FIFO models: wp written by stimulus, rp by the pop process
  logic [8:0] mem_a[64];
  logic [8:0] mem_b[64];
  int wp_a = 0, rp_a = 0, wp_b = 0, rp_b = 0;

  assign ef_a   = (wp_a == rp_a);
  assign ef_b   = (wp_b == rp_b);
  assign dout_b = mem_b[rp_b[5:0]];

  always @(posedge clk) begin
    if (rd_a) begin
      dout_a <= mem_a[rp_a[5:0]];
      rp_a   <= rp_a + 1;
    end
    if (rd_b) rp_b <= rp_b + 1;
  end

  fifo_lcd_bridge #(.FIFO_RD_LATENCY(1), .WORD_W(9)) u_a (
    .clk(clk), .rst(rst), .fifo_empty(ef_a), .fifo_dout(dout_a),
    .fifo_rd_en(rd_a), .init_done(init_done), .host_ready(rdy_a),
    .host_valid(v_a), .host_rs(rs_a),
`ifdef FIFO_LCD_BRIDGE_STATS_EN
    .txn_count(tc_a), .stall_flag(sf_a),
`endif
    .host_data(d_a)
  );

  fifo_lcd_bridge #(.FIFO_RD_LATENCY(0), .WORD_W(9)) u_b (
    .clk(clk), .rst(rst), .fifo_empty(ef_b), .fifo_dout(dout_b),
    .fifo_rd_en(rd_b), .init_done(init_done), .host_ready(rdy_b),
    .host_valid(v_b), .host_rs(rs_b),
`ifdef FIFO_LCD_BRIDGE_STATS_EN
    .txn_count(tc_b), .stall_flag(sf_b),
`endif
    .host_data(d_b)
  );

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic push_a(input logic [8:0] w, input bit expect_xfer);
    mem_a[wp_a[5:0]] = w;
    wp_a++;
    if (expect_xfer) sb_a.push_back(w);
  endtask

  task automatic push_b(input logic [8:0] w);
    mem_b[wp_b[5:0]] = w;
    wp_b++;
    sb_b.push_back(w);
  endtask

  task automatic wait_v_a();
    for (int i = 0; i < 30 && !v_a; i++) step();
    chk("wait_v_a", {31'd0, v_a}, 32'd1);
  endtask

  task automatic drain_a();
    for (int i = 0; i < 60 && sb_a.size() != 0; i++) step();
    chk("drain_a", sb_a.size(), 32'd0);
  endtask

  // transfer monitors: a transfer completes on the edge after this sample
  always @(negedge clk) begin
    if (rst) n_xfer_a = 0;
    else if (v_a && rdy_a) begin
      chk("xfer_a_expected", {31'd0, sb_a.size() > 0}, 32'd1);
      if (sb_a.size() > 0) chk("xfer_a_word", {23'd0, rs_a, d_a}, {23'd0, sb_a.pop_front()});
      n_xfer_a++;
    end
    if (!rst && v_b && rdy_b) begin
      chk("xfer_b_expected", {31'd0, sb_b.size() > 0}, 32'd1);
      if (sb_b.size() > 0) chk("xfer_b_word", {23'd0, rs_b, d_b}, {23'd0, sb_b.pop_front()});
    end
  end

  initial begin
    logic [8:0] cap;
    int cyc, last_rd, nrd;
    bit prev_v, prev_rd;

    rst = 1'b1; init_done = 1'b0; rdy_a = 1'b0; rdy_b = 1'b0;
    step(); step();
    chk("rst_rd_a", {31'd0, rd_a}, 0);
    chk("rst_v_a", {31'd0, v_a}, 0);
    chk("rst_rs_a", {31'd0, rs_a}, 0);
    chk("rst_d_a", {24'd0, d_a}, 0);
    chk("rst_v_b", {31'd0, v_b}, 0);
    chk("rst_rd_b", {31'd0, rd_b}, 0);

    // word waiting, init not done: nothing moves
    push_a(9'h141, 1);
    rst = 1'b0;
    repeat (10) begin
      step();
      chk("noinit_rd", {31'd0, rd_a}, 0);
      chk("noinit_v", {31'd0, v_a}, 0);
    end

    init_done = 1'b1;
    step(); chk("init_rd", {31'd0, rd_a}, 1); chk("init_v0", {31'd0, v_a}, 0);
    step(); chk("init_rd_once", {31'd0, rd_a}, 0); chk("init_v_wait", {31'd0, v_a}, 0);
    step(); chk("init_v", {31'd0, v_a}, 1);
    chk("init_rs", {31'd0, rs_a}, 1); chk("init_d", {24'd0, d_a}, 32'h41);

    // backpressure with another word queued: no pop, stable outputs
    push_a(9'h099, 1);
    repeat (20) begin
      step();
      chk("bp_v", {31'd0, v_a}, 1);
      chk("bp_rs", {31'd0, rs_a}, 1);
      chk("bp_d", {24'd0, d_a}, 32'h41);
      chk("bp_rd", {31'd0, rd_a}, 0);
    end
    rdy_a = 1'b1;
    step();
    chk("post_xfer_v", {31'd0, v_a}, 0);
    chk("post_xfer_pop", {31'd0, rd_a}, 1);
    drain_a();
    chk("hold_v", {31'd0, v_a}, 0);
    chk("hold_rs", {31'd0, rs_a}, 0);
    chk("hold_d", {24'd0, d_a}, 32'h99);

    // three words, ready held high
    push_a(9'h038, 1); push_a(9'h00C, 1); push_a(9'h148, 1);
    cyc = 0; last_rd = -100; nrd = 0; prev_v = 1'b0; prev_rd = 1'b0;
    repeat (20) begin
      step(); cyc++;
      if (rd_a) begin
        chk("rd_single_cycle", {31'd0, prev_rd}, 0);
        nrd++; last_rd = cyc;
      end
      if (v_a && !prev_v) chk("v_lat1", cyc - last_rd, 32'd2);
      prev_v = v_a; prev_rd = rd_a;
    end
    chk("rd_count", nrd, 32'd3);
    chk("sb_a_empty", sb_a.size(), 0);

    // FWFT instance
    rdy_b = 1'b1;
    push_b(9'h0AB); push_b(9'h1CD);
    step(); chk("b_rd0", {31'd0, rd_b}, 1); cap = dout_b;
    step(); chk("b_v0", {31'd0, v_b}, 1); chk("b_cap0", {23'd0, rs_b, d_b}, {23'd0, cap});
    chk("b_rd0_off", {31'd0, rd_b}, 0);
    step(); chk("b_rd1", {31'd0, rd_b}, 1); cap = dout_b;
    step(); chk("b_v1", {31'd0, v_b}, 1); chk("b_cap1", {23'd0, rs_b, d_b}, {23'd0, cap});
    step(); chk("b_idle", {31'd0, v_b}, 0);
    chk("sb_b_empty", sb_b.size(), 0);

    // reset while presenting: held word is dropped, next word follows
    rdy_a = 1'b0;
    push_a(9'h15A, 0); push_a(9'h033, 1);
    wait_v_a();
    chk("pre_rst_rs", {31'd0, rs_a}, 1); chk("pre_rst_d", {24'd0, d_a}, 32'h5A);
    rst = 1'b1;
    step();
    chk("mid_rst_rd", {31'd0, rd_a}, 0); chk("mid_rst_v", {31'd0, v_a}, 0);
    chk("mid_rst_rs", {31'd0, rs_a}, 0); chk("mid_rst_d", {24'd0, d_a}, 0);
    step(); chk("in_rst_rd", {31'd0, rd_a}, 0);
    rst = 1'b0; rdy_a = 1'b1;
    step(); chk("post_rst_pop", {31'd0, rd_a}, 1);
    drain_a();

    // init_done drop while a word is held
    rdy_a = 1'b0;
    push_a(9'h0C1, 1);
    wait_v_a();
    init_done = 1'b0;
    push_a(9'h0C2, 1);
    repeat (5) begin
      step();
      chk("noinit_hold_v", {31'd0, v_a}, 1);
      chk("noinit_hold_d", {24'd0, d_a}, 32'hC1);
      chk("noinit_hold_rd", {31'd0, rd_a}, 0);
    end
    rdy_a = 1'b1;
    step(); chk("noinit_xfer_v", {31'd0, v_a}, 0);
    repeat (5) begin
      step();
      chk("noinit_blk_rd", {31'd0, rd_a}, 0);
      chk("noinit_blk_v", {31'd0, v_a}, 0);
    end
    init_done = 1'b1;
    step(); chk("reinit_rd", {31'd0, rd_a}, 1);
    drain_a();

`ifdef FIFO_LCD_BRIDGE_STATS_EN
    rdy_a = 1'b0;
    push_a(9'h0E5, 1);
    wait_v_a();
    repeat (1023) step();
    chk("stall_not_yet", {31'd0, sf_a}, 0);
    step();
    chk("stall_set", {31'd0, sf_a}, 1);
    rdy_a = 1'b1;
    drain_a();
    repeat (3) step();
    chk("stall_sticky", {31'd0, sf_a}, 1);
    chk("txn_count", {16'd0, tc_a}, n_xfer_a & 32'hFFFF);
`endif

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
